// File: rtl/muldiv_unit_if.sv
// Handshake and operand/result bundle between the pipeline control and the
// iterative RV64M multiply/divide unit.
interface muldiv_unit_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] operandA;
    logic [WIDTH-1:0] operandB;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, op, operandA, operandB,
        input  ready, busy, done, result
    );

    modport slave (
        input  start, op, operandA, operandB,
        output ready, busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, with sign fix-up at the end.
// Divide-by-zero and signed overflow bypass the iteration entirely.
module muldiv_unit #(
    parameter int WIDTH = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    muldiv_unit_if.slave   bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {IDLE, CALC, FIX, DONE, DONE_SPECIAL} state_t;

    state_t           state, state_nx;
    logic [2:0]       op_q;
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [2*WIDTH-1:0] prod;     // multiply: product; divide: low half is quotient shift register
    logic [WIDTH:0]   rem;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] result_q;

    logic             in_sa, in_sb, div_zero, div_ovf, special;
    logic [WIDTH-1:0] in_a_mag, in_b_mag, special_val;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH+1:0] rem_sh, rem_diff;
    logic [WIDTH-1:0] hi_neg, fix_val;

    // Decode incoming operands: sign flags, magnitudes and divide special cases
    always_comb begin
        in_sa       = (bus.op inside {3'b001, 3'b010, 3'b100, 3'b110}) && bus.operandA[WIDTH-1];
        in_sb       = (bus.op inside {3'b001, 3'b100, 3'b110}) && bus.operandB[WIDTH-1];
        in_a_mag    = in_sa ? -bus.operandA : bus.operandA;
        in_b_mag    = in_sb ? -bus.operandB : bus.operandB;
        div_zero    = bus.op[2] && (bus.operandB == '0);
        div_ovf     = (bus.op inside {3'b100, 3'b110}) &&
                      (bus.operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.operandB == '1);
        special     = div_zero || div_ovf;
        special_val = '0;
        if (div_zero)
            special_val = bus.op[1] ? bus.operandA : '1;
        else
            special_val = bus.op[1] ? '0 : bus.operandA;
    end

    // One iteration step for each algorithm, plus the final sign-corrected result
    always_comb begin
        mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_mag} : '0);
        rem_sh   = {rem, prod[WIDTH-1]};
        rem_diff = rem_sh - {2'b00, b_mag};
        // upper half of the 128-bit two's complement without forming the full negation
        hi_neg   = ~prod[2*WIDTH-1:WIDTH] + {{(WIDTH-1){1'b0}}, (prod[WIDTH-1:0] == '0)};
        fix_val  = '0;
        case (op_q)
            3'b000:                 fix_val = prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_val = (sign_a ^ sign_b) ? hi_neg : prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fix_val = (sign_a ^ sign_b) ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
            default:                fix_val = sign_a ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:         if (bus.start) state_nx = special ? DONE_SPECIAL : CALC;
            CALC:         if (cnt == CW'(WIDTH - 1)) state_nx = FIX;
            FIX:          state_nx = DONE;
            DONE_SPECIAL: state_nx = DONE;
            DONE:         state_nx = IDLE;
            default:      state_nx = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        bus.ready  = (state == IDLE);
        bus.busy   = (state == CALC) || (state == FIX);
        bus.done   = (state == DONE);
        bus.result = result_q;
    end

    // Datapath: operand latch, iteration registers and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            a_mag    <= '0;
            b_mag    <= '0;
            prod     <= '0;
            rem      <= '0;
            cnt      <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    op_q   <= bus.op;
                    sign_a <= in_sa;
                    sign_b <= in_sb;
                    a_mag  <= in_a_mag;
                    b_mag  <= in_b_mag;
                    rem    <= '0;
                    cnt    <= '0;
                    // special-case answer is parked in prod until it is published
                    if (special)
                        prod <= {{WIDTH{1'b0}}, special_val};
                    else
                        prod <= {{WIDTH{1'b0}}, bus.op[2] ? in_a_mag : in_b_mag};
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (!op_q[2]) begin
                        prod <= {mul_sum, prod[WIDTH-1:1]};
                    end else begin
                        prod <= {prod[2*WIDTH-1:WIDTH], prod[WIDTH-2:0], ~rem_diff[WIDTH+1]};
                        rem  <= rem_diff[WIDTH+1] ? rem_sh[WIDTH:0] : rem_diff[WIDTH:0];
                    end
                end
                FIX:          result_q <= fix_val;
                DONE_SPECIAL: result_q <= prod[WIDTH-1:0];
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, randomized ops
// against an arithmetic reference model, and handshake robustness scenarios.
module tb_muldiv_unit;
    localparam int W = 64;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(W)) bus ();
    muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int   tests = 0;
    int   fails = 0;
    int   busy_seen;
    logic held_ok;

    function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sp;
        logic [127:0] up;
        logic ovf;
        ovf = (a == MINV) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
        case (o)
            3'd0: return a * b;
            3'd1: begin sp = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); return sp[127:64]; end
            3'd2: begin sp = $signed({{64{a[63]}}, a}) * $signed({64'd0, b}); return sp[127:64]; end
            3'd3: begin up = {64'd0, a} * {64'd0, b}; return up[127:64]; end
            3'd4: return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : ovf ? a : 64'($signed(a) / $signed(b));
            3'd5: return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 64'd0 : 64'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
        if (o[2] && b == 0) return 1;
        if ((o == 3'd4 || o == 3'd6) && a == MINV && b == 64'hFFFF_FFFF_FFFF_FFFF) return 1;
        return 65;
    endfunction

    // Issues one op from an IDLE cycle; returns in the cycle where done is seen (or on timeout)
    task automatic do_op(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] r, output int lat);
        logic [63:0] prev;
        prev = bus.result;
        held_ok = 1'b1;
        busy_seen = 0;
        bus.start = 1'b1; bus.op = o; bus.operandA = a; bus.operandB = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.op = 3'($urandom);
        bus.operandA = {$urandom, $urandom};
        bus.operandB = {$urandom, $urandom};
        lat = 0;
        while (bus.done !== 1'b1 && lat < 200) begin
            if (bus.busy === 1'b1) busy_seen++;
            if (bus.result !== prev) held_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        r = bus.result;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = '0; bus.operandA = '0; bus.operandB = '0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({bus.ready, bus.busy, bus.done} !== 3'b100 || bus.result !== 64'd0) begin
            fails++;
            $display("FAIL reset_state: ready/busy/done=%b result=%h, want 100 result=0",
                     {bus.ready, bus.busy, bus.done}, bus.result);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: ready=%b done=%b, want ready=1 done=0", bus.ready, bus.done);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  ops [11] = '{3'd0, 3'd3, 3'd1, 3'd4, 3'd6, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6, 3'd2};
        logic [63:0] as  [11] = '{64'd7, '1, '1, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9,
                                  64'd100, 64'h1234, 64'h1234, MINV, MINV, '1};
        logic [63:0] bs  [11] = '{64'hFFFF_FFFF_FFFF_FFFD, '1, '1, 64'd2, 64'd2, 64'd7, 64'd0, 64'd0,
                                  '1, '1, 64'd2};
        logic [63:0] ex  [11] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0,
                                  64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
                                  64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, MINV, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
        int          lx  [11] = '{65, 65, 65, 65, 65, 65, 1, 1, 1, 1, 65};
        logic [63:0] r;
        int lat;
        for (int i = 0; i < 11; i++) begin
            do_op(ops[i], as[i], bs[i], r, lat);
            tests++;
            if (r !== ex[i]) begin
                fails++;
                $display("FAIL directed_result[%0d] op=%0d: got %h, want %h", i, ops[i], r, ex[i]);
            end
            tests++;
            if (lat !== lx[i]) begin
                fails++;
                $display("FAIL directed_latency[%0d]: got %0d edges, want %0d", i, lat, lx[i]);
            end
            tests++;
            if (busy_seen !== ((lx[i] == 65) ? 65 : 0) || held_ok !== 1'b1) begin
                fails++;
                $display("FAIL directed_busy_hold[%0d]: busy cycles %0d held=%b, want %0d held=1",
                         i, busy_seen, held_ok, (lx[i] == 65) ? 65 : 0);
            end
            @(posedge clk); #1;
            tests++;
            if (bus.done !== 1'b0 || bus.ready !== 1'b1 || bus.result !== ex[i]) begin
                fails++;
                $display("FAIL directed_pulse[%0d]: done=%b ready=%b result=%h, want 0 1 %h",
                         i, bus.done, bus.ready, bus.result, ex[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] a, b, r, e;
        logic [2:0] o;
        int lat;
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 9))
                0: b = 64'd0;
                1: begin a = MINV; b = '1; end
                2: a = 64'($urandom_range(0, 50));
                3: b = 64'($urandom_range(1, 9));
                4: b = -64'($urandom_range(1, 9));
                5: a = '1;
                default: ;
            endcase
            e = ref_op(o, a, b);
            do_op(o, a, b, r, lat);
            tests++;
            if (r !== e || lat !== ref_lat(o, a, b)) begin
                fails++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h lat %0d, want %h lat %0d",
                         i, o, a, b, r, lat, e, ref_lat(o, a, b));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_start_ignored();
        int n;
        bus.start = 1'b1; bus.op = 3'd4; bus.operandA = 64'd1000; bus.operandB = 64'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0;
        while (bus.done !== 1'b1 && n < 200) begin
            if (n == 9) begin
                bus.start = 1'b1; bus.op = 3'd7; bus.operandA = 64'd5; bus.operandB = 64'd3;
            end
            if (n == 10) bus.start = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (bus.result !== 64'd142 || n !== 65) begin
            fails++;
            $display("FAIL start_ignored: result %h after %0d edges, want %h after 65", bus.result, n, 64'd142);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        logic [63:0] a, b, r;
        int n, lat;
        bus.start = 1'b1; bus.op = 3'd0; bus.operandA = 64'h1234_5678; bus.operandB = 64'd9;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (n = 0; n < 30; n++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.ready, bus.busy, bus.done} !== 3'b100 || bus.result !== 64'd0) begin
            fails++;
            $display("FAIL reset_abort: ready/busy/done=%b result=%h, want 100 result=0",
                     {bus.ready, bus.busy, bus.done}, bus.result);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        do_op(3'd3, a, b, r, lat);
        tests++;
        if (r !== ref_op(3'd3, a, b) || lat !== 65) begin
            fails++;
            $display("FAIL after_abort: got %h lat %0d, want %h lat 65", r, lat, ref_op(3'd3, a, b));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [63:0] r;
        int lat;
        do_op(3'd5, 64'd99, 64'd10, r, lat);
        bus.start = 1'b1; bus.op = 3'd0; bus.operandA = 64'd3; bus.operandB = 64'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.result !== 64'd9) begin
            fails++;
            $display("FAIL done_cycle_start: ready=%b busy=%b result=%h, want 1 0 %h",
                     bus.ready, bus.busy, bus.result, 64'd9);
        end
        do_op(3'd0, 64'd3, 64'd5, r, lat);
        tests++;
        if (r !== 64'd15 || lat !== 65) begin
            fails++;
            $display("FAIL back_to_back: got %h lat %0d, want %h lat 65", r, lat, 64'd15);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
